// File: rtl/product_select_ctrl.sv
// Product selection sequencer for the sale terminal.
// Browses product IDs with wrap-around, locks a choice on confirm, blinks the
// ID display while locked and drops back to a blank display on idle timeout.
module product_select_ctrl #(
    parameter int NUM_PRODUCTS = 10,
    parameter int TIMEOUT_CYC  = 250000000,
    parameter int BLINK_CYC    = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_ok,
    input  logic       btn_cancel,
    input  logic       txn_done,
    output logic [3:0] sel_id,
    output logic       sel_valid,
    output logic       disp_en,
    output logic       confirm_pls,
    output logic [1:0] state_o
);

    // Counter widths; a parameter of 1 still gets a 1-bit counter.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [3:0]    LAST_ID    = 4'(NUM_PRODUCTS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BROWSE = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    id_q, id_d;
    logic          valid_q, valid_d;
    logic          disp_q, disp_d;
    logic          conf_q, conf_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] blink_q, blink_d;

    // Neighbouring IDs with wrap-around at both ends of the range.
    logic [3:0] id_inc, id_dec;
    assign id_inc = (id_q == LAST_ID) ? 4'd0 : id_q + 4'd1;
    assign id_dec = (id_q == 4'd0) ? LAST_ID : id_q - 4'd1;

    // State and registered outputs; async reset returns everything to blank idle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= 4'd0;
            valid_q <= 1'b0;
            disp_q  <= 1'b0;
            conf_q  <= 1'b0;
            timer_q <= '0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            disp_q  <= disp_d;
            conf_q  <= conf_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
        end
    end

    // Next state and next outputs; button priority is cancel > ok > next > prev.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        id_d    = id_q;
        valid_d = valid_q;
        disp_d  = disp_q;
        conf_d  = 1'b0;
        timer_d = '0;
        blink_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                disp_d  = 1'b0;
                if (btn_next) begin
                    state_d = ST_BROWSE;
                    id_d    = 4'd0;
                    disp_d  = 1'b1;
                end else if (btn_prev) begin
                    state_d = ST_BROWSE;
                    id_d    = LAST_ID;
                    disp_d  = 1'b1;
                end
            end

            ST_BROWSE: begin
                disp_d = 1'b1;
                if (btn_cancel) begin
                    state_d = ST_IDLE;
                    id_d    = 4'd0;
                    disp_d  = 1'b0;
                end else if (btn_ok) begin
                    state_d = ST_LOCKED;
                    valid_d = 1'b1;
                    conf_d  = 1'b1;
                end else if (btn_next) begin
                    id_d = id_inc;
                end else if (btn_prev) begin
                    id_d = id_dec;
                end else if (timer_q == TIMER_LAST) begin
                    // Idle too long with no operator activity: blank out.
                    state_d = ST_IDLE;
                    id_d    = 4'd0;
                    disp_d  = 1'b0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            ST_LOCKED: begin
                if (btn_cancel) begin
                    state_d = ST_BROWSE;
                    valid_d = 1'b0;
                    disp_d  = 1'b1;
                end else if (txn_done) begin
                    state_d = ST_IDLE;
                    id_d    = 4'd0;
                    valid_d = 1'b0;
                    disp_d  = 1'b0;
                end else if (blink_q == BLINK_LAST) begin
                    disp_d = ~disp_q;
                end else begin
                    blink_d = blink_q + BLINK_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                id_d    = 4'd0;
                valid_d = 1'b0;
                disp_d  = 1'b0;
            end
        endcase
    end

    assign sel_id      = id_q;
    assign sel_valid   = valid_q;
    assign disp_en     = disp_q;
    assign confirm_pls = conf_q;
    assign state_o     = state_q;

endmodule
